// File: rtl/fifo_word_packer_pkg.sv
// Shared constants and types for the FIFO byte-to-word packer.
package fifo_word_packer_pkg;

    localparam int unsigned PK_DATA_W = 8;
    localparam int unsigned PK_BYTES  = 4;
    localparam int unsigned PK_WORD_W = PK_DATA_W * PK_BYTES;
    localparam int unsigned PK_CNT_W  = $clog2(PK_BYTES + 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pk_state_t;

    // Keep mask with the low n lanes set.
    function automatic logic [PK_BYTES-1:0] keep_mask(input logic [PK_CNT_W-1:0] n);
        logic [PK_BYTES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < PK_BYTES; i++) begin
            if (PK_CNT_W'(i) < n) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// FIFO pop side plus packed-word valid/ready stream; master is the packer.
interface fifo_word_packer_if;
    import fifo_word_packer_pkg::*;

    logic                 fifo_empty;
    logic                 fifo_rd_en;
    logic [PK_DATA_W-1:0] fifo_data;
    logic                 flush;
    logic [PK_WORD_W-1:0] out_data;
    logic [PK_BYTES-1:0]  out_keep;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        input  fifo_empty, fifo_data, flush, out_ready,
        output fifo_rd_en, out_data, out_keep, out_last, out_valid
    );

    modport slave (
        output fifo_empty, fifo_data, flush, out_ready,
        input  fifo_rd_en, out_data, out_keep, out_last, out_valid
    );

endinterface

// File: rtl/fifo_word_packer.sv
// Drains a one-cycle-latency byte FIFO and packs bytes little-endian into
// words; a flush emits the partial word with keep flags and out_last.
module fifo_word_packer
    import fifo_word_packer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    fifo_word_packer_if.master  bus_io
);

    pk_state_t            state_q;
    logic [PK_CNT_W-1:0]  count_q;
    logic [PK_CNT_W-1:0]  count_d;
    logic                 inflight_q;
    logic                 flush_pend_q;
    logic [PK_WORD_W-1:0] data_q;
    logic [PK_WORD_W-1:0] data_d;
    logic [PK_BYTES-1:0]  keep_q;
    logic                 last_q;
    logic                 rd_en_c;

    // Never issue more pops than free lanes, counting the byte still in flight.
    assign rd_en_c = (state_q == FILL) && !bus_io.fifo_empty && !flush_pend_q &&
                     ((count_q + PK_CNT_W'(inflight_q)) < PK_CNT_W'(PK_BYTES)) && !rst;

    // Lane write decode for the landing byte.
    always_comb begin
        data_d  = data_q;
        count_d = count_q + PK_CNT_W'(1);
        for (int unsigned i = 0; i < PK_BYTES; i++) begin
            if (count_q == PK_CNT_W'(i)) begin
                data_d[i*PK_DATA_W +: PK_DATA_W] = bus_io.fifo_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            count_q      <= '0;
            inflight_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            data_q       <= '0;
            keep_q       <= '0;
            last_q       <= 1'b0;
        end else begin
            inflight_q <= rd_en_c;
            unique case (state_q)
                FILL: begin
                    if (inflight_q) begin
                        data_q  <= data_d;
                        count_q <= count_d;
                    end
                    if (inflight_q && (count_d == PK_CNT_W'(PK_BYTES))) begin
                        // A flush landing with the last byte closes this full word.
                        state_q      <= HOLD;
                        keep_q       <= keep_mask(count_d);
                        last_q       <= flush_pend_q | bus_io.flush;
                        flush_pend_q <= flush_pend_q | bus_io.flush;
                    end else if (flush_pend_q && !inflight_q) begin
                        if (count_q != '0) begin
                            state_q <= HOLD;
                            keep_q  <= keep_mask(count_q);
                            last_q  <= 1'b1;
                        end else begin
                            flush_pend_q <= 1'b0;
                        end
                    end else if (bus_io.flush) begin
                        flush_pend_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus_io.out_ready) begin
                        state_q <= FILL;
                        count_q <= '0;
                        data_q  <= '0;
                        keep_q  <= '0;
                        last_q  <= 1'b0;
                        if (last_q) begin
                            flush_pend_q <= 1'b0;
                        end
                    end else if (bus_io.flush) begin
                        last_q       <= 1'b1;
                        flush_pend_q <= 1'b1;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign bus_io.fifo_rd_en = rd_en_c;
    assign bus_io.out_valid  = (state_q == HOLD);
    assign bus_io.out_data   = data_q;
    assign bus_io.out_keep   = keep_q;
    assign bus_io.out_last   = last_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with a behavioural one-cycle-latency FIFO.
module tb_fifo_word_packer;

    logic clk = 1'b0;
    logic rst;
    fifo_word_packer_if bus();

    fifo_word_packer dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural FIFO: data appears the cycle after an accepted pop.
    logic [7:0] mem [0:63];
    int   wr_ptr   = 0;
    int   rd_ptr   = 0;
    logic pause_en = 1'b0;
    logic pause_ph = 1'b0;

    assign bus.fifo_empty = (wr_ptr == rd_ptr) || (pause_en && pause_ph);

    always @(posedge clk) begin
        if (bus.fifo_rd_en && !bus.fifo_empty) begin
            bus.fifo_data <= mem[rd_ptr % 64];
            rd_ptr        <= rd_ptr + 1;
        end
        pause_ph <= pause_en ? !pause_ph : 1'b0;
    end

    logic [31:0] wq [$];
    logic [3:0]  kq [$];
    logic        lq [$];

    always @(posedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            wq.push_back(bus.out_data);
            kq.push_back(bus.out_keep);
            lq.push_back(bus.out_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 64] = b;
        wr_ptr++;
    endtask

    task automatic clear_words();
        wq.delete();
        kq.delete();
        lq.delete();
    endtask

    task automatic wait_words(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (wq.size() >= n) break;
            tick();
        end
        ok = (wq.size() >= n);
    endtask

    function automatic logic [31:0] word_at(input int k);
        return (wq.size() > k) ? wq[k] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [3:0] keep_at(input int k);
        return (kq.size() > k) ? kq[k] : 4'hx;
    endfunction

    function automatic logic last_at(input int k);
        return (lq.size() > k) ? lq[k] : 1'bx;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en got=%b exp=0", bus.fifo_rd_en); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 32'h0) begin n_bad++; $display("FAIL reset_data got=%h exp=0", bus.out_data); end
        n_cmp++; if (bus.out_keep !== 4'h0) begin n_bad++; $display("FAIL reset_keep got=%h exp=0", bus.out_keep); end
        n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL reset_last got=%b exp=0", bus.out_last); end
        rst = 1'b0;
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_valid got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_full_words();
        int pops[$];
        int first_valid;
        first_valid = -1;
        clear_words();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(8'(8'h11 * (i + 1)));
        #1;
        for (int c = 0; c < 20; c++) begin
            if (bus.fifo_rd_en) pops.push_back(c);
            if (bus.out_valid && first_valid < 0) first_valid = c;
            tick();
        end
        n_cmp++; if (pops.size() != 8) begin n_bad++; $display("FAIL full_pop_count got=%0d exp=8", pops.size()); end
        n_cmp++; if ((pops.size() > 3 ? pops[3] : -1) != 3) begin n_bad++; $display("FAIL full_pop3_cycle got=%0d exp=3", pops.size() > 3 ? pops[3] : -1); end
        n_cmp++; if ((pops.size() > 4 ? pops[4] : -1) != 6) begin n_bad++; $display("FAIL full_pop4_cycle got=%0d exp=6", pops.size() > 4 ? pops[4] : -1); end
        n_cmp++; if (first_valid != 5) begin n_bad++; $display("FAIL full_valid_cycle got=%0d exp=5", first_valid); end
        n_cmp++; if (wq.size() != 2) begin n_bad++; $display("FAIL full_word_count got=%0d exp=2", wq.size()); end
        n_cmp++; if (word_at(0) !== 32'h4433_2211) begin n_bad++; $display("FAIL full_word0 got=%h exp=44332211", word_at(0)); end
        n_cmp++; if (keep_at(0) !== 4'hF || last_at(0) !== 1'b0) begin n_bad++; $display("FAIL full_word0_flags got=keep %h last %b exp=keep f last 0", keep_at(0), last_at(0)); end
        n_cmp++; if (word_at(1) !== 32'h8877_6655) begin n_bad++; $display("FAIL full_word1 got=%h exp=88776655", word_at(1)); end
        n_cmp++; if (keep_at(1) !== 4'hF || last_at(1) !== 1'b0) begin n_bad++; $display("FAIL full_word1_flags got=keep %h last %b exp=keep f last 0", keep_at(1), last_at(1)); end
    endtask

    task automatic test_partial_flush();
        clear_words();
        bus.out_ready = 1'b1;
        push(8'hA1); push(8'hB2); push(8'hC3);
        #1;
        for (int c = 0; c < 6; c++) tick();
        n_cmp++; if (wq.size() != 0) begin n_bad++; $display("FAIL pflush_premature got=%0d words exp=0", wq.size()); end
        bus.flush = 1'b1;
        n_cmp++; if (bus.fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL pflush_rd_en_f0 got=%b exp=0", bus.fifo_rd_en); end
        tick();
        bus.flush = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL pflush_f1 got=valid %b rd %b exp=0 0", bus.out_valid, bus.fifo_rd_en); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL pflush_f2 got=valid %b rd %b exp=1 0", bus.out_valid, bus.fifo_rd_en); end
        n_cmp++; if (bus.out_data !== 32'h00C3_B2A1) begin n_bad++; $display("FAIL pflush_data got=%h exp=00c3b2a1", bus.out_data); end
        n_cmp++; if (bus.out_keep !== 4'h7 || bus.out_last !== 1'b1) begin n_bad++; $display("FAIL pflush_flags got=keep %h last %b exp=keep 7 last 1", bus.out_keep, bus.out_last); end
        tick();
        n_cmp++; if (wq.size() != 1 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL pflush_handshake got=%0d words valid %b exp=1 words valid 0", wq.size(), bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit seen;
        seen = 1'b0;
        clear_words();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        #1;
        for (int c = 0; c < 20; c++) begin
            if (bus.out_valid) begin seen = 1'b1; break; end
            tick();
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL bp_valid_timeout got=no valid exp=valid within 20 cycles"); end
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1312_1110 || bus.fifo_rd_en !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold_c%0d got=valid %b data %h rd %b exp=1 13121110 0", c, bus.out_valid, bus.out_data, bus.fifo_rd_en);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++; if (bus.fifo_rd_en !== 1'b1 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_resume got=rd %b valid %b exp=1 0", bus.fifo_rd_en, bus.out_valid); end
        wait_words(2, 30, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_words_timeout got=%0d exp=2", wq.size()); end
        n_cmp++; if (word_at(0) !== 32'h1312_1110 || word_at(1) !== 32'h1716_1514) begin n_bad++; $display("FAIL bp_words got=%h %h exp=13121110 17161514", word_at(0), word_at(1)); end
    endtask

    task automatic test_flush_edges();
        bit ok;
        bit saw;
        saw = 1'b0;
        clear_words();
        bus.out_ready = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (bus.out_valid) saw = 1'b1;
            tick();
        end
        n_cmp++; if (saw || wq.size() != 0) begin n_bad++; $display("FAIL empty_flush_word got=valid_seen %b words %0d exp=0 0", saw, wq.size()); end
        push(8'h21); push(8'h22); push(8'h23); push(8'h24);
        #1;
        wait_words(1, 30, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL empty_flush_stuck got=%0d words exp=1", wq.size()); end
        n_cmp++; if (word_at(0) !== 32'h2423_2221 || last_at(0) !== 1'b0) begin n_bad++; $display("FAIL empty_flush_next got=%h last %b exp=24232221 last 0", word_at(0), last_at(0)); end

        clear_words();
        bus.out_ready = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(8'h31 + i));
        #1;
        for (int c = 0; c < 20; c++) begin
            if (bus.out_valid) begin saw = 1'b1; break; end
            tick();
        end
        n_cmp++; if (!saw || bus.out_last !== 1'b0) begin n_bad++; $display("FAIL hold_flush_pre got=valid %b last %b exp=1 0", saw, bus.out_last); end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        n_cmp++; if (bus.out_last !== 1'b1 || bus.out_data !== 32'h3433_3231) begin n_bad++; $display("FAIL hold_flush_last got=last %b data %h exp=1 34333231", bus.out_last, bus.out_data); end
        tick();
        bus.out_ready = 1'b1;
        wait_words(2, 30, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL hold_flush_timeout got=%0d words exp=2", wq.size()); end
        n_cmp++; if (word_at(0) !== 32'h3433_3231 || keep_at(0) !== 4'hF || last_at(0) !== 1'b1) begin n_bad++; $display("FAIL hold_flush_w0 got=%h keep %h last %b exp=34333231 f 1", word_at(0), keep_at(0), last_at(0)); end
        n_cmp++; if (word_at(1) !== 32'h3837_3635 || last_at(1) !== 1'b0) begin n_bad++; $display("FAIL hold_flush_w1 got=%h last %b exp=38373635 last 0", word_at(1), last_at(1)); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_words();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) push(8'(8'h41 + i));
        #1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL rmid_rd_en got=%b exp=0", bus.fifo_rd_en); end
        tick();
        rst = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_keep !== 4'h0 || bus.out_last !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_outputs got=valid %b data %h keep %h last %b exp=all 0", bus.out_valid, bus.out_data, bus.out_keep, bus.out_last);
        end
        wait_words(1, 30, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmid_timeout got=%0d words exp=1", wq.size()); end
        n_cmp++; if (word_at(0) !== 32'h4746_4544 || keep_at(0) !== 4'hF) begin n_bad++; $display("FAIL rmid_word got=%h keep %h exp=47464544 f", word_at(0), keep_at(0)); end
    endtask

    task automatic test_empty_pause();
        bit ok;
        clear_words();
        bus.out_ready = 1'b1;
        pause_en = 1'b1;
        for (int i = 0; i < 8; i++) push(8'(i + 1));
        #1;
        wait_words(2, 80, ok);
        pause_en = 1'b0;
        for (int c = 0; c < 12; c++) tick();
        n_cmp++; if (!ok || wq.size() != 2) begin n_bad++; $display("FAIL pause_count got=%0d words exp=2", wq.size()); end
        n_cmp++; if (word_at(0) !== 32'h0403_0201) begin n_bad++; $display("FAIL pause_w0 got=%h exp=04030201", word_at(0)); end
        n_cmp++; if (word_at(1) !== 32'h0807_0605) begin n_bad++; $display("FAIL pause_w1 got=%h exp=08070605", word_at(1)); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_words();
        test_partial_flush();
        test_backpressure();
        test_flush_edges();
        test_reset_mid();
        test_empty_pause();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Downstream drain stage for the 8-bit synchronous FIFO. It pops bytes through the FIFO's `rd_en`/`empty`/`data_out` interface, which has one-cycle read latency. It packs the bytes little-endian into 32-bit words and presents them on a valid/ready output stream. A flush request emits a partial word with byte-keep flags, so a packet tail never stalls in the packer.

## Interface
- `DATA_W`, 8: FIFO byte width.
- `BYTES`, 4: bytes per output word; `out_data` is `DATA_W*BYTES` wide.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd_en` out 1: FIFO pop request.
- `fifo_data` in DATA_W: FIFO read data, valid the cycle after an accepted pop.
- `flush` in 1: single-cycle pulse requesting emission of any partial word.
- `out_data` out DATA_W*BYTES: packed word; first byte in bits [7:0]; unused lanes are 0.
- `out_keep` out BYTES: per-lane valid flags.
- `out_last` out 1: word closes a flush.
- `out_valid` out 1: word available.
- `out_ready` in 1: consumer accepts the word.

## Operation
- States:
  - FILL: collecting bytes.
  - HOLD: word presented, waiting for handshake.
- Registers:
  - `count`, 0..BYTES: bytes captured.
  - `inflight`: a pop was accepted last cycle.
  - `flush_pend`: a flush request is pending.
- **Pop rule:** `fifo_rd_en = (state==FILL) && !fifo_empty && !flush_pend && (count+inflight < BYTES) && !rst`.
  - The signal is combinational from registers and `fifo_empty`.
  - A pop is accepted when `fifo_rd_en` is high.
- **Capture:** when `inflight` is high, `fifo_data` is written to lane `count`, and `count` increments.
- **FILL→HOLD:** when the capture makes `count==BYTES`, or when `flush_pend && !inflight && count>0`.
  - Entering HOLD sets `out_keep` to the low `count` bits set.
  - It sets `out_last = flush_pend`.
- **Flush with no data:** `flush_pend && !inflight && count==0` clears `flush_pend`. No word is emitted; the block never emits a zero-keep word.
- **HOLD:** `out_valid=1`, and `out_data`, `out_keep` and `out_last` are stable.
  - On `out_valid && out_ready`: go to FILL, clear `count`, `out_data`, `out_keep` and `out_last`.
  - If `out_last` was set, also clear `flush_pend`.
- **`flush` sets `flush_pend`:**
  - In FILL, the accepted pop in flight still lands; then the partial word is emitted.
  - If `flush` arrives while in HOLD, or in the same cycle the word fills, that full word carries `out_last=1` and consumes the flush.
- **`flush` while `flush_pend` is already set:** ignored, no queueing.
- **Reset:** clears all state.
  - Outputs are 0 during and after reset: `fifo_rd_en`, `out_valid`, `out_data`, `out_keep`, `out_last`.
  - Any pop in flight at reset is discarded.

## Timing
- Pop in cycle n → `fifo_data` is sampled at the end of cycle n+1.
- FIFO never empty, `out_ready=1`:
  - Pops occur in cycles 0–3.
  - `out_valid` is high in cycle 5.
  - The next pop is in cycle 6.
  - Steady state is 1 word per 6 cycles.
- `out_valid` never deasserts before the handshake, and data is stable while `out_valid && !out_ready`.
- Flush latency:
  - With no pop in flight, `out_valid` rises 1 cycle after `flush` is sampled.
  - With a pop in flight, `out_valid` rises 2 cycles after.
- `fifo_empty` going high mid-word pauses pops. `count` holds indefinitely; there is no timeout.

## Structure
- Shared package holds:
  - Constants `PK_DATA_W` (8) and `PK_BYTES` (4).
  - `pk_state_t` enum `{FILL, HOLD}`.
  - `PK_WORD_W = PK_DATA_W*PK_BYTES`.
- There is no sub-module; lane write-enable decode is inline. The block connects directly to the FIFO instance at the parent level.

## Test plan
- **Full words:** FIFO preloaded with 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88; `out_ready=1`.
  - Words 0x44332211 then 0x88776655.
  - `out_keep=4'hF`, `out_last=0`.
  - First `out_valid` 5 cycles after the first pop.
- **Partial flush:** push 0xA1,0xB2,0xC3, let them drain, pulse `flush`.
  - One word 0x00C3B2A1, `out_keep=4'h7`, `out_last=1`.
  - `fifo_rd_en` stays low from the `flush` cycle until handshake.
- **Backpressure:** full word pending with `out_ready=0` for 10 cycles.
  - `out_valid` held, data stable, `fifo_rd_en=0` throughout.
  - Handshake on release, pops resume the next cycle.
- **Flush edge cases:**
  - `flush` with `count==0` and nothing in flight → no output word, `flush_pend` clears.
  - `flush` during HOLD → that full word has `out_last=1`.
  - The next word has `out_last=0`.
- **Reset mid-word:** assert `rst` for 1 cycle after 2 bytes are captured, with a pop in flight.
  - All outputs 0 in the following cycle.
  - The next word starts from lane 0 and excludes the in-flight byte.
- **Empty pause:** `fifo_empty` toggles every cycle while bytes 0x01..0x08 are supplied.
  - Words 0x04030201 and 0x08070605; no byte is lost or duplicated.
